// File: rtl/mul_issue_ctrl_if.sv
// Handshake and multiplier-side bundle for mul_issue_ctrl.
// master = issue logic, result consumer and multiplier; slave = controller.
interface mul_issue_ctrl_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [1:0]            op_i;
    logic [XLEN-1:0]       a_i;
    logic [XLEN-1:0]       b_i;
    logic [TAG_W-1:0]      tag_i;
    logic                  flush_i;
    logic [XLEN-1:0]       mul_a_o;
    logic [XLEN-1:0]       mul_b_o;
    logic                  mul_unsign_a_o;
    logic                  mul_unsign_b_o;
    logic [2*XLEN-1:0]     mul_s_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [XLEN-1:0]       res_o;
    logic [TAG_W-1:0]      res_tag_o;

    modport master (
        output in_valid_i, op_i, a_i, b_i, tag_i, flush_i, mul_s_i, res_ready_i,
        input  in_ready_o, mul_a_o, mul_b_o, mul_unsign_a_o, mul_unsign_b_o,
               res_valid_o, res_o, res_tag_o
    );

    modport slave (
        input  in_valid_i, op_i, a_i, b_i, tag_i, flush_i, mul_s_i, res_ready_i,
        output in_ready_o, mul_a_o, mul_b_o, mul_unsign_a_o, mul_unsign_b_o,
               res_valid_o, res_o, res_tag_o
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for a multicycle combinational RV M-extension multiplier.
// Optional MUL_RESULT_REUSE_EN: reuse the last full product when operands and signedness match.
module mul_issue_ctrl #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_issue_ctrl_if.slave  bus
);
    localparam int unsigned      CNT_W    = 4;
    localparam int unsigned      PROD_W   = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   tag_q;
    logic [1:0]         op_q;
    logic               accept;
    logic               complete;
    logic               req_ua;
    logic               req_ub;
    logic               hit;
    logic [XLEN-1:0]    hit_res;

    // MUL returns the low half; all high-half ops return the upper half.
    function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op,
                                                 input logic [PROD_W-1:0] p);
        return (op == OP_MUL) ? p[XLEN-1:0] : p[PROD_W-1:XLEN];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush dominates completion and accept
    always_comb begin
        state_nxt = state;
        if (bus.flush_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nxt = hit ? DONE : BUSY;
                BUSY: if (cnt == '0) state_nxt = DONE;
                DONE: begin
                    if (bus.res_ready_i) begin
                        if (accept) state_nxt = hit ? DONE : BUSY;
                        else        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output/decode logic: handshake, signedness decode, completion strobe
    always_comb begin
        bus.in_ready_o  = 1'b0;
        bus.res_valid_o = 1'b0;
        accept          = 1'b0;
        complete        = 1'b0;
        req_ua          = 1'b0;
        req_ub          = 1'b0;

        bus.in_ready_o  = !bus.flush_i &&
                          ((state == IDLE) || ((state == DONE) && bus.res_ready_i));
        accept          = bus.in_valid_i && bus.in_ready_o;
        complete        = (state == BUSY) && (cnt == '0) && !bus.flush_i;
        bus.res_valid_o = (state == DONE);

        unique case (bus.op_i)
            OP_MUL:    begin req_ua = 1'b0; req_ub = 1'b0; end
            OP_MULH:   begin req_ua = 1'b0; req_ub = 1'b0; end
            OP_MULHSU: begin req_ua = 1'b0; req_ub = 1'b1; end
            OP_MULHU:  begin req_ua = 1'b1; req_ub = 1'b1; end
            default:   begin req_ua = 1'b0; req_ub = 1'b0; end
        endcase
    end

    // Operand, counter and result registers; a flush freezes everything but state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.mul_a_o        <= '0;
            bus.mul_b_o        <= '0;
            bus.mul_unsign_a_o <= 1'b0;
            bus.mul_unsign_b_o <= 1'b0;
            bus.res_o          <= '0;
            bus.res_tag_o      <= '0;
            cnt                <= '0;
            tag_q              <= '0;
            op_q               <= OP_MUL;
        end else if (accept) begin
            bus.mul_a_o        <= bus.a_i;
            bus.mul_b_o        <= bus.b_i;
            bus.mul_unsign_a_o <= req_ua;
            bus.mul_unsign_b_o <= req_ub;
            tag_q              <= bus.tag_i;
            op_q               <= bus.op_i;
            cnt                <= CNT_INIT;
            if (hit) begin
                bus.res_o     <= hit_res;
                bus.res_tag_o <= bus.tag_i;
            end
        end else if (complete) begin
            bus.res_o     <= sel_half(op_q, bus.mul_s_i);
            bus.res_tag_o <= tag_q;
        end else if ((state == BUSY) && !bus.flush_i) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef MUL_RESULT_REUSE_EN
    logic [PROD_W-1:0] rp_prod;
    logic [XLEN-1:0]   rp_a;
    logic [XLEN-1:0]   rp_b;
    logic              rp_ua;
    logic              rp_ub;
    logic              rp_vld;

    // Remember the last product that actually completed (flushed ops never get here)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp_prod <= '0;
            rp_a    <= '0;
            rp_b    <= '0;
            rp_ua   <= 1'b0;
            rp_ub   <= 1'b0;
            rp_vld  <= 1'b0;
        end else if (complete) begin
            rp_prod <= bus.mul_s_i;
            rp_a    <= bus.mul_a_o;
            rp_b    <= bus.mul_b_o;
            rp_ua   <= bus.mul_unsign_a_o;
            rp_ub   <= bus.mul_unsign_b_o;
            rp_vld  <= 1'b1;
        end
    end

    // Low half is signedness-independent, so MUL only needs the operands to match
    always_comb begin
        hit     = rp_vld && (bus.a_i == rp_a) && (bus.b_i == rp_b) &&
                  ((bus.op_i == OP_MUL) || ({req_ua, req_ub} == {rp_ua, rp_ub}));
        hit_res = sel_half(bus.op_i, rp_prod);
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed self-checking bench for mul_issue_ctrl (XLEN=64, MUL_CYCLES=2) with a behavioural multiplier.
module tb_mul_issue_ctrl;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned MUL_CYCLES = 2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Edges from accept (inclusive) until res_valid_o is seen
    localparam int NORMAL_EDGES = MUL_CYCLES + 1;
`ifdef MUL_RESULT_REUSE_EN
    localparam int REUSE_EDGES = 1;
`else
    localparam int REUSE_EDGES = NORMAL_EDGES;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    mul_issue_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference multiplier: extend per signedness control, keep 128 bits
    logic [127:0] ext_a, ext_b;
    always_comb begin
        ext_a = bus.mul_unsign_a_o ? {64'd0, bus.mul_a_o} : {{64{bus.mul_a_o[63]}}, bus.mul_a_o};
        ext_b = bus.mul_unsign_b_o ? {64'd0, bus.mul_b_o} : {{64{bus.mul_b_o[63]}}, bus.mul_b_o};
        bus.mul_s_i = ext_a * ext_b;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] tag);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.tag_i      = tag;
    endtask

    // Issue one op from IDLE and wait (bounded) for its result; result is left pending
    task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp_res,
                          input logic exp_ua, input logic exp_ub, input int exp_edges);
        int edges;
        drive_req(op, a, b, tag);
        #1;
        check({name, "_in_ready"}, 128'(bus.in_ready_o), 128'(1));
        tick();
        bus.in_valid_i = 1'b0;
        edges = 1;
        check({name, "_unsign"}, 128'({bus.mul_unsign_a_o, bus.mul_unsign_b_o}),
              128'({exp_ua, exp_ub}));
        while (!bus.res_valid_o && edges < 20) begin
            check({name, "_mul_a_stable"}, 128'(bus.mul_a_o), 128'(a));
            tick();
            edges++;
        end
        check({name, "_latency"}, 128'(edges), 128'(exp_edges));
        check({name, "_res"}, 128'(bus.res_o), 128'(exp_res));
        check({name, "_tag"}, 128'(bus.res_tag_o), 128'(tag));
    endtask

    task automatic drain(input string name);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        check({name, "_drained"}, 128'(bus.res_valid_o), 128'(0));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_i        = OP_MUL;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.tag_i       = '0;
        bus.flush_i     = 1'b0;
        bus.res_ready_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid",    128'(bus.res_valid_o), 128'(0));
        check("rst_res",      128'(bus.res_o),       128'(0));
        check("rst_tag",      128'(bus.res_tag_o),   128'(0));
        check("rst_mul_a",    128'(bus.mul_a_o),     128'(0));
        check("rst_unsign",   128'({bus.mul_unsign_a_o, bus.mul_unsign_b_o}), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready_o),  128'(1));
        rst_n = 1'b1;
        tick();

        // Basic ops
        run_op("mul_neg", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd7,
               64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, NORMAL_EDGES);
        drain("mul_neg");
        run_op("mulhu_m1", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, NORMAL_EDGES);
        drain("mulhu_m1");
        run_op("mulh_m1", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
               64'h0, 1'b0, 1'b0, NORMAL_EDGES);
        drain("mulh_m1");
        run_op("mulhsu_m1", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, NORMAL_EDGES);
        drain("mulhsu_m1");

        // Backpressure: 2^63 * 4 = 2^65, high half = 2
        run_op("bp", OP_MULHU, 64'h8000_0000_0000_0000, 64'd4, 5'd2,
               64'd2, 1'b1, 1'b1, NORMAL_EDGES);
        drive_req(OP_MUL, 64'd6, 64'd7, 5'd3);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 128'(bus.in_ready_o),  128'(0));
            check("bp_valid",    128'(bus.res_valid_o), 128'(1));
            check("bp_res",      128'(bus.res_o),       128'(2));
            check("bp_tag",      128'(bus.res_tag_o),   128'(2));
            tick();
        end
        check("bp_not_accepted", 128'(bus.mul_a_o), 128'(64'h8000_0000_0000_0000));

        // Back-to-back: release result and accept the pending request on the same edge
        bus.res_ready_i = 1'b1;
        #1;
        check("b2b_in_ready", 128'(bus.in_ready_o), 128'(1));
        tick();
        bus.in_valid_i  = 1'b0;
        bus.res_ready_i = 1'b0;
        check("b2b_busy0", 128'(bus.res_valid_o), 128'(0));
        check("b2b_mul_a", 128'(bus.mul_a_o),     128'(6));
        tick();
        check("b2b_busy1", 128'(bus.res_valid_o), 128'(0));
        tick();
        check("b2b_valid", 128'(bus.res_valid_o), 128'(1));
        check("b2b_res",   128'(bus.res_o),       128'(42));
        check("b2b_tag",   128'(bus.res_tag_o),   128'(3));
        drain("b2b");

        // Flush one cycle after accept
        drive_req(OP_MUL, 64'd9, 64'd9, 5'd4);
        tick();
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b1;
        #1;
        check("flush_in_ready_low", 128'(bus.in_ready_o), 128'(0));
        tick();
        bus.flush_i = 1'b0;
        #1;
        check("flush_in_ready", 128'(bus.in_ready_o), 128'(1));
        for (int i = 0; i < 4; i++) begin
            check("flush_no_valid", 128'(bus.res_valid_o), 128'(0));
            tick();
        end
        run_op("after_flush", OP_MUL, 64'd9, 64'd9, 5'd4, 64'd81, 1'b0, 1'b0, NORMAL_EDGES);
        drain("after_flush");

        // Reset mid-BUSY
        drive_req(OP_MUL, 64'd11, 64'd13, 5'd9);
        tick();
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstb_valid",  128'(bus.res_valid_o), 128'(0));
        check("rstb_res",    128'(bus.res_o),       128'(0));
        check("rstb_tag",    128'(bus.res_tag_o),   128'(0));
        check("rstb_mul_a",  128'(bus.mul_a_o),     128'(0));
        check("rstb_mul_b",  128'(bus.mul_b_o),     128'(0));
        check("rstb_unsign", 128'({bus.mul_unsign_a_o, bus.mul_unsign_b_o}), 128'(0));
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rstb_no_valid", 128'(bus.res_valid_o), 128'(0));
            tick();
        end

        // Repeat operands: MULHU then MUL on 5*7 (second may hit when reuse is built in)
        run_op("rep_mulhu", OP_MULHU, 64'd5, 64'd7, 5'd6, 64'd0, 1'b1, 1'b1, NORMAL_EDGES);
        drain("rep_mulhu");
        run_op("rep_mul", OP_MUL, 64'd5, 64'd7, 5'd8, 64'd35, 1'b0, 1'b0, REUSE_EDGES);
        drain("rep_mul");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
